// File: rtl/ahblite_counter.sv
// AHB-Lite timer/counter: prescaled 32-bit down-counter, one-shot/periodic, sticky flag, level IRQ.
// Optional prescaler built when COUNTER_PRESCALER_EN is defined; otherwise every cycle is a tick.
module ahblite_counter #(
  parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ_CNT
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_LOAD   = 3'd1;
  localparam logic [2:0] A_VALUE  = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_PRESC  = 3'd4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic        valid_q, valid_d;
  logic        periodic_q, periodic_d;
  logic        irqen_q, irqen_d;
  logic        flag_q, flag_d;
  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic        tick;
  logic        wr_en, ctrl_wr, load_wr, status_wr;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, HPROT};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ_CNT   = flag_q & irqen_q;

  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    valid_d = valid_q;
    if (HREADY) begin
      valid_d = HSEL & HTRANS[1];
      if (HSEL & HTRANS[1]) begin
        addr_d  = HADDR[4:2];
        write_d = HWRITE;
      end
    end
  end

  assign wr_en     = valid_q & write_q;
  assign ctrl_wr   = wr_en && (addr_q == A_CTRL);
  assign load_wr   = wr_en && (addr_q == A_LOAD);
  assign status_wr = wr_en && (addr_q == A_STATUS);

`ifdef COUNTER_PRESCALER_EN
  logic [7:0] presc_q, presc_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       presc_wr;

  assign presc_wr = wr_en && (addr_q == A_PRESC);
  assign tick     = (pcnt_q == presc_q);

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (presc_wr) presc_d = HWDATA[7:0];
    if (state_q == IDLE) begin
      if (ctrl_wr && HWDATA[0]) pcnt_d = 8'd0;
    end else begin
      pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      presc_q <= 8'd0;
      pcnt_q  <= 8'd0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    periodic_d = periodic_q;
    irqen_d    = irqen_q;
    flag_d     = flag_q;
    load_d     = load_q;
    value_d    = value_q;
    if (load_wr) load_d = HWDATA;
    if (ctrl_wr) begin
      periodic_d = HWDATA[1];
      irqen_d    = HWDATA[2];
    end
    // Clear is applied first so a same-edge expiry below overrides it.
    if (status_wr && HWDATA[0]) flag_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_wr && HWDATA[0]) begin
          state_d = RUN;
          value_d = load_q;
        end
      end
      RUN: begin
        if (tick) begin
          if (value_q != 32'd0) begin
            value_d = value_q - 32'd1;
          end else begin
            flag_d = 1'b1;
            if (periodic_q) value_d = load_q;
            else            state_d = IDLE;
          end
        end
        // A software stop freezes VALUE but still lets an expiry on this edge set FLAG.
        if (ctrl_wr && !HWDATA[0]) begin
          state_d = IDLE;
          value_d = value_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      addr_q     <= 3'd0;
      write_q    <= 1'b0;
      valid_q    <= 1'b0;
      periodic_q <= 1'b0;
      irqen_q    <= 1'b0;
      flag_q     <= 1'b0;
      load_q     <= RESET_LOAD;
      value_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      valid_q    <= valid_d;
      periodic_q <= periodic_d;
      irqen_q    <= irqen_d;
      flag_q     <= flag_d;
      load_q     <= load_d;
      value_q    <= value_d;
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (valid_q && !write_q) begin
      case (addr_q)
        A_CTRL:   HRDATA = {29'd0, irqen_q, periodic_q, state_q == RUN};
        A_LOAD:   HRDATA = load_q;
        A_VALUE:  HRDATA = value_q;
        A_STATUS: HRDATA = {31'd0, flag_q};
`ifdef COUNTER_PRESCALER_EN
        A_PRESC:  HRDATA = {24'd0, presc_q};
`endif
        default:  HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_counter.sv
// Directed bench for ahblite_counter: bus access, one-shot, periodic, collisions and async reset.
module tb_ahblite_counter;

  localparam logic [31:0] R_CTRL   = 32'h00;
  localparam logic [31:0] R_LOAD   = 32'h04;
  localparam logic [31:0] R_VALUE  = 32'h08;
  localparam logic [31:0] R_STATUS = 32'h0C;
  localparam logic [31:0] R_PRESC  = 32'h10;
  localparam logic [31:0] R_RSVD   = 32'h14;
  localparam logic [31:0] RST_LOAD = 32'h0000_1234;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        IRQ_CNT;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rdata_v;

  ahblite_counter #(.RESET_LOAD(RST_LOAD)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .IRQ_CNT(IRQ_CNT)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
    step();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    step();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    step();
  endtask

  task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HSIZE = 3'b010;
    HPROT = 4'd0; HWRITE = 1'b0; HWDATA = 32'd0; HREADY = 1'b1;
    repeat (3) step();
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_irq", {31'd0, IRQ_CNT}, 32'd0);
    chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("hresp", {31'd0, HRESP}, 32'd0);
    HRESET = 1'b0;
    step();
    rchk("rst_ctrl", R_CTRL, 32'd0);
    rchk("rst_load", R_LOAD, RST_LOAD);
    rchk("rst_value", R_VALUE, 32'd0);
    rchk("rst_status", R_STATUS, 32'd0);

    // Back-to-back write then read of LOAD.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = R_LOAD; HWRITE = 1'b1;
    step();
    HWDATA = 32'hDEAD_BEEF; HWRITE = 1'b0;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("b2b_load", HRDATA, 32'hDEAD_BEEF);
    chk("b2b_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("b2b_hresp", {31'd0, HRESP}, 32'd0);
    step();
    wr(R_VALUE, 32'h55);
    rchk("value_ro", R_VALUE, 32'd0);
    wr(R_RSVD, 32'hFFFF_FFFF);
    rchk("rsvd_zero", R_RSVD, 32'd0);
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = R_LOAD; HWRITE = 1'b1;
    step();
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'd0;
    step();
    rchk("idle_xfer", R_LOAD, 32'hDEAD_BEEF);

    // Start, stop at 7, restart with new LOAD, LOAD change while running.
    wr(R_LOAD, 32'd10);
    wr(R_CTRL, 32'd1);
    rchk("start_value", R_VALUE, 32'd9);
    wr(R_CTRL, 32'd0);
    rchk("stop_hold7", R_VALUE, 32'd7);
    rchk("stop_ctrl", R_CTRL, 32'd0);
    wr(R_LOAD, 32'd20);
    wr(R_CTRL, 32'd1);
    rchk("restart_value", R_VALUE, 32'd19);
    wr(R_LOAD, 32'd100);
    rchk("load_in_run", R_VALUE, 32'd15);
    wr(R_CTRL, 32'd0);

    // One-shot LOAD=5: IRQ rises 6 edges after start.
    wr(R_LOAD, 32'd5);
    wr(R_CTRL, 32'd5);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("oneshot_irq_%0d", i), {31'd0, IRQ_CNT}, {31'd0, i == 6});
    end
    rchk("oneshot_ctrl", R_CTRL, 32'd4);
    rchk("oneshot_value", R_VALUE, 32'd0);
    rchk("oneshot_flag", R_STATUS, 32'd1);
    wr(R_STATUS, 32'd0);
    rchk("status_w0", R_STATUS, 32'd1);
    wr(R_STATUS, 32'd1);
    chk("clear_irq", {31'd0, IRQ_CNT}, 32'd0);
    rchk("status_w1", R_STATUS, 32'd0);

    // CTRL stop on the same edge as one-shot expiry.
    wr(R_LOAD, 32'd2);
    wr(R_CTRL, 32'd5);
    step();
    wr(R_CTRL, 32'd4);
    rchk("stop_expiry_flag", R_STATUS, 32'd1);
    rchk("stop_expiry_ctrl", R_CTRL, 32'd4);
    wr(R_STATUS, 32'd1);

    // Periodic with LOAD=0: flag on every tick.
    wr(R_LOAD, 32'd0);
    wr(R_CTRL, 32'd7);
    step();
    chk("load0_irq", {31'd0, IRQ_CNT}, 32'd1);
    rchk("load0_value", R_VALUE, 32'd0);
    wr(R_STATUS, 32'd1);
    rchk("load0_reset_flag", R_STATUS, 32'd1);
    wr(R_CTRL, 32'd0);
    wr(R_STATUS, 32'd1);
    rchk("load0_cleared", R_STATUS, 32'd0);

    // Periodic LOAD=3, no prescale: flag every 4 edges; clear/set collision.
    wr(R_LOAD, 32'd3);
    wr(R_CTRL, 32'd7);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("per_irq_%0d", i), {31'd0, IRQ_CNT}, {31'd0, i == 4});
    end
    repeat (2) step();
    wr(R_STATUS, 32'd1);
    rchk("collide_set_wins", R_STATUS, 32'd1);
    step();
    wr(R_STATUS, 32'd1);
    rchk("per_cleared", R_STATUS, 32'd0);
    step();
    chk("per_reset_irq", {31'd0, IRQ_CNT}, 32'd1);
    rchk("per_reload", R_VALUE, 32'd2);
    wr(R_CTRL, 32'd0);
    wr(R_STATUS, 32'd1);

`ifdef COUNTER_PRESCALER_EN
    wr(R_PRESC, 32'd2);
    rchk("presc_rw", R_PRESC, 32'd2);
    wr(R_LOAD, 32'd3);
    wr(R_CTRL, 32'd7);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i >= 11) chk($sformatf("presc_irq_%0d", i), {31'd0, IRQ_CNT}, {31'd0, i == 12});
    end
    wr(R_STATUS, 32'd1);
    repeat (9) step();
    chk("presc_irq_23", {31'd0, IRQ_CNT}, 32'd0);
    step();
    chk("presc_irq_24", {31'd0, IRQ_CNT}, 32'd1);
    rchk("presc_reload", R_VALUE, 32'd3);
    wr(R_CTRL, 32'd0);
    wr(R_STATUS, 32'd1);
`else
    wr(R_PRESC, 32'd5);
    rchk("presc_absent", R_PRESC, 32'd0);
`endif

    // Asynchronous reset in the middle of a read data phase while counting.
    wr(R_LOAD, 32'd0);
    wr(R_CTRL, 32'd7);
    repeat (4) step();
    chk("pre_rst_irq", {31'd0, IRQ_CNT}, 32'd1);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = R_CTRL; HWRITE = 1'b0;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("pre_rst_ctrl", HRDATA, 32'd7);
    #2 HRESET = 1'b1;
    #1;
    chk("async_rst_irq", {31'd0, IRQ_CNT}, 32'd0);
    chk("async_rst_hrdata", HRDATA, 32'd0);
    step();
    HRESET = 1'b0;
    rchk("post_rst_ctrl", R_CTRL, 32'd0);
    rchk("post_rst_load", R_LOAD, RST_LOAD);
    rchk("post_rst_value", R_VALUE, 32'd0);
    rchk("post_rst_status", R_STATUS, 32'd0);
    rchk("post_rst_presc", R_PRESC, 32'd0);
    rd(R_VALUE, rdata_v);
    chk("post_rst_idle", rdata_v, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
